// File: rtl/multimode_game_ctrl.sv
// -----------------------------------------------------------------------------
// multimode_game_ctrl
//
// Up/down counter game. Each enabled step moves the counter by +1, +STEP_BIG,
// -1 or -STEP_BIG, wrapping modulo 2^WIDTH. A step that lands on all-ones
// scores a win, and a step that lands on zero scores a loss. After every hit
// the counter spends one RELOAD cycle returning to the last value loaded by
// init. A tally that reaches TARGET ends the game in OVER. The game stays in
// OVER until game_ack is seen.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   init         load request: count and load_val take initial_val (PLAY only)
//   initial_val  value loaded on init
//   control      step mode: 0=+1, 1=+STEP_BIG, 2=-1, 3=-STEP_BIG
//   enable       step qualifier (init has priority)
//   game_ack     releases OVER back to PLAY
//   count        current counter value
//   winner       one-cycle pulse, a step landed on all-ones
//   loser        one-cycle pulse, a step landed on zero
//   win_tally    winner pulses this game
//   lose_tally   loser pulses this game
//   gameover     high for the whole OVER state
//   who          0 = none, 1 = loser finished, 2 = winner finished
// -----------------------------------------------------------------------------
module multimode_game_ctrl #(
  parameter int WIDTH    = 4,
  parameter int SCORE_W  = 4,
  parameter int TARGET   = 15,
  parameter int STEP_BIG = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   initial_val,
  input  logic [1:0]         control,
  input  logic               enable,
  input  logic               game_ack,
  output logic [WIDTH-1:0]   count,
  output logic               winner,
  output logic               loser,
  output logic [SCORE_W-1:0] win_tally,
  output logic [SCORE_W-1:0] lose_tally,
  output logic               gameover,
  output logic [1:0]         who
);

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   STEP_W   = WIDTH'(STEP_BIG);
  localparam logic [SCORE_W-1:0] ONE_T    = {{(SCORE_W-1){1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0] ZERO_T   = {SCORE_W{1'b0}};
  localparam logic [SCORE_W-1:0] TARGET_T = SCORE_W'(TARGET);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_RELOAD = 2'd1,
    ST_OVER   = 2'd2
  } state_t;

  state_t             state_r,      state_s;
  logic [WIDTH-1:0]   count_r,      count_s;
  logic [WIDTH-1:0]   load_val_r,   load_val_s;
  logic               winner_r,     winner_s;
  logic               loser_r,      loser_s;
  logic [SCORE_W-1:0] win_tally_r,  win_tally_s;
  logic [SCORE_W-1:0] lose_tally_r, lose_tally_s;
  logic               gameover_r,   gameover_s;
  logic [1:0]         who_r,        who_s;
  logic [WIDTH-1:0]   step_s;
  logic [WIDTH-1:0]   stepped_s;

  // Step size and candidate count value; the subtraction wraps modulo 2^WIDTH.
  always_comb begin
    step_s    = control[0] ? STEP_W : ONE_W;
    stepped_s = control[1] ? (count_r - step_s) : (count_r + step_s);
  end

  // Next-state and next-output logic. Every output is computed here and then
  // registered, so a hit pulse appears together with the count that caused it.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    load_val_s   = load_val_r;
    winner_s     = 1'b0;
    loser_s      = 1'b0;
    win_tally_s  = win_tally_r;
    lose_tally_s = lose_tally_r;
    gameover_s   = gameover_r;
    who_s        = who_r;

    case (state_r)
      ST_PLAY: begin
        if (init) begin
          count_s    = initial_val;
          load_val_s = initial_val;
        end else if (enable) begin
          count_s = stepped_s;
          if (stepped_s == ONES_W) begin
            winner_s    = 1'b1;
            win_tally_s = win_tally_r + ONE_T;
            state_s     = ST_RELOAD;
          end else if (stepped_s == ZERO_W) begin
            loser_s      = 1'b1;
            lose_tally_s = lose_tally_r + ONE_T;
            state_s      = ST_RELOAD;
          end else begin
            state_s = ST_PLAY;
          end
        end else begin
          count_s = count_r;
        end
      end

      ST_RELOAD: begin
        // The reload value is never compared against the hit values, so a
        // load_val of 0 or all-ones does not raise a flag.
        count_s = load_val_r;
        if (win_tally_r == TARGET_T) begin
          who_s      = 2'd2;
          gameover_s = 1'b1;
          state_s    = ST_OVER;
        end else if (lose_tally_r == TARGET_T) begin
          who_s      = 2'd1;
          gameover_s = 1'b1;
          state_s    = ST_OVER;
        end else begin
          state_s = ST_PLAY;
        end
      end

      ST_OVER: begin
        if (game_ack) begin
          win_tally_s  = ZERO_T;
          lose_tally_s = ZERO_T;
          count_s      = load_val_r;
          who_s        = 2'd0;
          gameover_s   = 1'b0;
          state_s      = ST_PLAY;
        end else begin
          gameover_s = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean PLAY.
        state_s    = ST_PLAY;
        gameover_s = 1'b0;
        who_s      = 2'd0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_PLAY;
      count_r      <= ZERO_W;
      load_val_r   <= ZERO_W;
      winner_r     <= 1'b0;
      loser_r      <= 1'b0;
      win_tally_r  <= ZERO_T;
      lose_tally_r <= ZERO_T;
      gameover_r   <= 1'b0;
      who_r        <= 2'd0;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      load_val_r   <= load_val_s;
      winner_r     <= winner_s;
      loser_r      <= loser_s;
      win_tally_r  <= win_tally_s;
      lose_tally_r <= lose_tally_s;
      gameover_r   <= gameover_s;
      who_r        <= who_s;
    end
  end

  assign count      = count_r;
  assign winner     = winner_r;
  assign loser      = loser_r;
  assign win_tally  = win_tally_r;
  assign lose_tally = lose_tally_r;
  assign gameover   = gameover_r;
  assign who        = who_r;

endmodule

// File: tb/tb_multimode_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multimode_game_ctrl
//
// Directed bench for multimode_game_ctrl (WIDTH=4, SCORE_W=4, TARGET=3,
// STEP_BIG=2). The driver applies one input vector per cycle on the falling
// edge and pushes the hand-computed outputs expected after the next rising
// edge. A separate monitor pops and compares them shortly after that edge.
// -----------------------------------------------------------------------------
module tb_multimode_game_ctrl;

  typedef struct packed {
    logic [3:0] count;
    logic       winner;
    logic       loser;
    logic [3:0] win_tally;
    logic [3:0] lose_tally;
    logic       gameover;
    logic [1:0] who;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       init;
  logic [3:0] initial_val;
  logic [1:0] control;
  logic       enable;
  logic       game_ack;
  logic [3:0] count;
  logic       winner;
  logic       loser;
  logic [3:0] win_tally;
  logic [3:0] lose_tally;
  logic       gameover;
  logic [1:0] who;

  obs_t got;
  obs_t exp_q[$];
  int   id_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  multimode_game_ctrl #(
    .WIDTH(4), .SCORE_W(4), .TARGET(3), .STEP_BIG(2)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .initial_val(initial_val),
    .control(control), .enable(enable), .game_ack(game_ack),
    .count(count), .winner(winner), .loser(loser),
    .win_tally(win_tally), .lose_tally(lose_tally),
    .gameover(gameover), .who(who)
  );

  assign got = '{count, winner, loser, win_tally, lose_tally, gameover, who};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input int id, input obs_t g, input obs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s step%0d got cnt=%0d w=%0b l=%0b wt=%0d lt=%0d go=%0b who=%0d expected cnt=%0d w=%0b l=%0b wt=%0d lt=%0d go=%0b who=%0d",
               name, id, g.count, g.winner, g.loser, g.win_tally, g.lose_tally, g.gameover, g.who,
               e.count, e.winner, e.loser, e.win_tally, e.lose_tally, e.gameover, e.who);
    end
  endtask

  // One cycle of stimulus plus the outputs expected after the following edge.
  task automatic cyc(input logic i_init, input logic [3:0] iv, input logic [1:0] ctl,
                     input logic en, input logic ack,
                     input logic [3:0] e_cnt, input logic e_w, input logic e_l,
                     input logic [3:0] e_wt, input logic [3:0] e_lt,
                     input logic e_go, input logic [1:0] e_who);
    obs_t e;
    @(negedge clk);
    init        = i_init;
    initial_val = iv;
    control     = ctl;
    enable      = en;
    game_ack    = ack;
    e = '{e_cnt, e_w, e_l, e_wt, e_lt, e_go, e_who};
    step_id++;
    exp_q.push_back(e);
    id_q.push_back(step_id);
  endtask

  // Monitor: after every rising edge, compare against the oldest expectation.
  initial begin
    obs_t e;
    int   id;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        compare("scoreboard", id, got, e);
      end
    end
  end

  // Stimulus.
  initial begin
    obs_t zero_obs;
    zero_obs    = '0;
    rst         = 1'b1;
    init        = 1'b0;
    initial_val = 4'd0;
    control     = 2'd0;
    enable      = 1'b0;
    game_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    compare("reset_state", 0, got, zero_obs);
    @(negedge clk);
    rst = 1'b0;

    //   init iv     ctl   en    ack     cnt    w     l     wt    lt    go    who
    // Load 13 and count up to a win. The reload returns to 13.
    cyc(1'b1, 4'd13, 2'd0, 1'b0, 1'b0,  4'd13, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b1, 1'b0,  4'd14, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b1, 1'b0,  4'd15, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b1, 1'b0,  4'd13, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0);
    // A big down step wraps from 1 to 15 and scores a win.
    cyc(1'b1, 4'd1,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd3, 1'b1, 1'b0,  4'd15, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 2'd0);
    // Count down 2 -> 1 -> 0 to score a loss.
    cyc(1'b1, 4'd2,  2'd0, 1'b0, 1'b0,  4'd2,  1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd2, 1'b1, 1'b0,  4'd1,  1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd2, 1'b1, 1'b0,  4'd0,  1'b0, 1'b1, 4'd2, 4'd1, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd2,  1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 2'd0);
    // init beats enable: loading 0 is not a hit. count then holds while idle.
    cyc(1'b1, 4'd0,  2'd2, 1'b1, 1'b0,  4'd0,  1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 4'd0, 2'd1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 2'd0);
    // Third win reaches TARGET, which leads to OVER with who=2.
    cyc(1'b1, 4'd14, 2'd0, 1'b0, 1'b0,  4'd14, 1'b0, 1'b0, 4'd2, 4'd1, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b1, 1'b0,  4'd15, 1'b1, 1'b0, 4'd3, 4'd1, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd14, 1'b0, 1'b0, 4'd3, 4'd1, 1'b1, 2'd2);
    // Inputs other than game_ack are ignored in OVER.
    cyc(1'b1, 4'd5,  2'd1, 1'b1, 1'b0,  4'd14, 1'b0, 1'b0, 4'd3, 4'd1, 1'b1, 2'd2);
    cyc(1'b0, 4'd0,  2'd3, 1'b1, 1'b0,  4'd14, 1'b0, 1'b0, 4'd3, 4'd1, 1'b1, 2'd2);
    // game_ack clears the game. The count returns to load_val=14, not 5.
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b1,  4'd14, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b1,  4'd14, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    // Three losses interleaved with two wins, which ends with who=1.
    cyc(1'b1, 4'd1,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd2, 1'b1, 1'b0,  4'd0,  1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd3, 1'b1, 1'b0,  4'd15, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd2, 1'b1, 1'b0,  4'd0,  1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd3, 1'b1, 1'b0,  4'd15, 1'b1, 1'b0, 4'd2, 4'd2, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd2, 1'b1, 1'b0,  4'd0,  1'b0, 1'b1, 4'd2, 4'd3, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd2, 4'd3, 1'b1, 2'd1);
    cyc(1'b0, 4'd0,  2'd0, 1'b1, 1'b0,  4'd1,  1'b0, 1'b0, 4'd2, 4'd3, 1'b1, 2'd1);
    cyc(1'b1, 4'd9,  2'd0, 1'b0, 1'b0,  4'd1,  1'b0, 1'b0, 4'd2, 4'd3, 1'b1, 2'd1);

    // Asynchronous reset between edges while in OVER.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    compare("async_reset", step_id, got, zero_obs);
    @(negedge clk);
    rst      = 1'b0;
    init     = 1'b0;
    enable   = 1'b0;
    control  = 2'd0;

    // After reset load_val is 0, so the next reload returns the count to 0.
    cyc(1'b0, 4'd0,  2'd0, 1'b1, 1'b0,  4'd1,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd3, 1'b1, 1'b0,  4'd15, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0);
    cyc(1'b0, 4'd0,  2'd0, 1'b0, 1'b0,  4'd0,  1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 2'd0);
    enable = 1'b0;

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
